// File: rtl/imem_loader.sv
// Instruction-memory front end: streams a program into a word array over valid/ready,
// holds the core in reset until loading settles, then serves combinational fetches.
module imem_loader #(
   parameter int unsigned DEPTH    = 64,
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned HOLD_CYC = 2,
   parameter logic [31:0] NOP_WORD = 32'h00000013
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   input  logic              in_last,
   output logic              in_ready,
   input  logic              reload,
   input  logic [63:0]       fetch_addr,
   output logic [31:0]       fetch_inst,
   output logic              cpu_rst,
   output logic [ADDR_W:0]   word_count,
   output logic              overflow,
   output logic              loaded
);

   localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [3:0]      HOLD_LAST = 4'(HOLD_CYC - 1);

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W:0]   word_count_q, word_count_d;
   logic [3:0]        hold_cnt_q, hold_cnt_d;
   logic              overflow_q, overflow_d;
   logic              wr_en;
   logic [31:0]       mem_q [DEPTH];

   logic [ADDR_W-1:0] fetch_idx;
   logic              fetch_hi_zero;
   logic              fetch_hit;
   logic              unused_addr_bits;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent simulation results.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= ST_LOAD;
         word_count_q <= '0;
         hold_cnt_q   <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_count_q <= word_count_d;
         hold_cnt_q   <= hold_cnt_d;
         overflow_q   <= overflow_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      word_count_d = word_count_q;
      hold_cnt_d   = hold_cnt_q;
      overflow_d   = overflow_q;
      wr_en        = 1'b0;
      in_ready     = 1'b0;
      cpu_rst      = 1'b1;
      loaded       = 1'b0;

      case (state_q)
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wr_en        = 1'b1;
               word_count_d = word_count_q + 1'b1;
               // Filling the last slot without in_last ends the program as if it were last.
               if (in_last || (word_count_q == LAST_IDX)) begin
                  state_d    = ST_HOLD;
                  hold_cnt_d = '0;
                  if (!in_last) begin
                     overflow_d = 1'b1;
                  end
               end
            end
         end

         ST_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
               state_d = ST_RUN;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end

         ST_RUN: begin
            cpu_rst = 1'b0;
            loaded  = 1'b1;
            if (reload) begin
               state_d      = ST_LOAD;
               word_count_d = '0;
               overflow_d   = 1'b0;
            end
         end

         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   // NOTE: the array has no reset; stale contents are masked by word_count on fetch.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_q[word_count_q[ADDR_W-1:0]] <= in_data;
      end
   end

   // Fetch ignores the byte offset; PCs above the array or past the loaded words read as NOP.
   assign fetch_idx        = fetch_addr[ADDR_W+1:2];
   assign fetch_hi_zero    = (fetch_addr[63:ADDR_W+2] == '0);
   assign fetch_hit        = (state_q == ST_RUN) && fetch_hi_zero &&
                             ({1'b0, fetch_idx} < word_count_q);
   assign fetch_inst       = fetch_hit ? mem_q[fetch_idx] : NOP_WORD;
   assign unused_addr_bits = ^fetch_addr[1:0];

   assign word_count = word_count_q;
   assign overflow   = overflow_q;

endmodule
